// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader and its ROM/RAM peers:
// word/address widths, the frame start marker and the loader state encoding.
package inst_mem_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_ADDR_L = 4'd2,
    ST_ADDR_H = 4'd3,
    ST_CNT_L  = 4'd4,
    ST_CNT_H  = 4'd5,
    ST_DAT_L  = 4'd6,
    ST_DAT_H  = 4'd7,
    ST_WRITE  = 4'd8,
    ST_CSUM   = 4'd9,
    ST_FIN    = 4'd10
  } loader_state_t;

  // States in which the loader is prepared to take a byte from the stream.
  // WRITE is excluded so the byte source is stalled while a word is in flight.
  function automatic logic rx_ready_for(input loader_state_t s);
    logic v;
    case (s)
      ST_SYNC, ST_ADDR_L, ST_ADDR_H, ST_CNT_L, ST_CNT_H,
      ST_DAT_L, ST_DAT_H, ST_CSUM: v = 1'b1;
      default:                     v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: parses a framed byte stream
// (sync, base address, word count, data words, XOR checksum) and writes each
// 16-bit word to instruction memory over a ce/we/ack port, holding the CPU
// via o_busy until the image is in place.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter bit                CHECKSUM_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mem_ce,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [WORD_W-1:0] o_words_written
);

  loader_state_t     r_state;
  logic              r_rx_ready;
  logic              r_mem_ce;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [WORD_W-1:0] r_words_written;
  logic [WORD_W-1:0] r_count;
  logic [BYTE_W-1:0] r_csum;

  logic              w_byte_fire;
  logic [WORD_W-1:0] w_ww_inc;
  logic [WORD_W-1:0] w_count_full;
  loader_state_t     w_tail_state;

  // A byte is consumed only when the loader itself advertised readiness.
  assign w_byte_fire  = i_rx_valid & r_rx_ready;
  assign w_ww_inc     = r_words_written + 16'd1;
  assign w_count_full = {i_rx_data, r_count[7:0]};
  // Where the frame goes once the data words are done: the checksum byte,
  // or straight to FIN when the image carries no checksum.
  assign w_tail_state = CHECKSUM_EN ? ST_CSUM : ST_FIN;

  assign o_rx_ready      = r_rx_ready;
  assign o_mem_ce        = r_mem_ce;
  assign o_mem_we        = r_mem_ce;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_words_written = r_words_written;

  // Frame parser FSM; every output is registered alongside the state so the
  // memory port and the CPU hold never glitch, and reset kills a write at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_rx_ready      <= 1'b0;
      r_mem_ce        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_words_written <= '0;
      r_count         <= '0;
      r_csum          <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (i_start) begin
            r_state         <= ST_SYNC;
            r_rx_ready      <= rx_ready_for(ST_SYNC);
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_words_written <= '0;
            r_csum          <= '0;
          end
        end

        ST_SYNC: begin
          if (w_byte_fire && (i_rx_data == SYNC_BYTE)) begin
            r_state    <= ST_ADDR_L;
            r_rx_ready <= rx_ready_for(ST_ADDR_L);
          end
        end

        ST_ADDR_L: begin
          if (w_byte_fire) begin
            r_mem_addr[7:0] <= i_rx_data;
            r_csum          <= r_csum ^ i_rx_data;
            r_state         <= ST_ADDR_H;
            r_rx_ready      <= rx_ready_for(ST_ADDR_H);
          end
        end

        ST_ADDR_H: begin
          if (w_byte_fire) begin
            r_mem_addr[15:8] <= i_rx_data;
            r_csum           <= r_csum ^ i_rx_data;
            r_state          <= ST_CNT_L;
            r_rx_ready       <= rx_ready_for(ST_CNT_L);
          end
        end

        ST_CNT_L: begin
          if (w_byte_fire) begin
            r_count[7:0] <= i_rx_data;
            r_csum       <= r_csum ^ i_rx_data;
            r_state      <= ST_CNT_H;
            r_rx_ready   <= rx_ready_for(ST_CNT_H);
          end
        end

        ST_CNT_H: begin
          if (w_byte_fire) begin
            r_count[15:8] <= i_rx_data;
            r_csum        <= r_csum ^ i_rx_data;
            if (w_count_full == '0) begin
              r_state    <= w_tail_state;
              r_rx_ready <= rx_ready_for(w_tail_state);
              r_busy     <= (w_tail_state != ST_FIN);
              r_done     <= (w_tail_state == ST_FIN);
            end else begin
              r_state    <= ST_DAT_L;
              r_rx_ready <= rx_ready_for(ST_DAT_L);
            end
          end
        end

        ST_DAT_L: begin
          if (w_byte_fire) begin
            r_mem_wdata[7:0] <= i_rx_data;
            r_csum           <= r_csum ^ i_rx_data;
            r_state          <= ST_DAT_H;
            r_rx_ready       <= rx_ready_for(ST_DAT_H);
          end
        end

        ST_DAT_H: begin
          if (w_byte_fire) begin
            r_mem_wdata[15:8] <= i_rx_data;
            r_csum            <= r_csum ^ i_rx_data;
            r_state           <= ST_WRITE;
            r_rx_ready        <= rx_ready_for(ST_WRITE);
            r_mem_ce          <= 1'b1;
          end
        end

        ST_WRITE: begin
          // ack is only honoured from inside WRITE, so a write always lasts
          // at least one cycle even if the memory holds ack high on entry
          if (i_mem_ack) begin
            r_mem_ce        <= 1'b0;
            r_words_written <= w_ww_inc;
            r_mem_addr      <= r_mem_addr + 16'd1;
            if (w_ww_inc < r_count) begin
              r_state    <= ST_DAT_L;
              r_rx_ready <= rx_ready_for(ST_DAT_L);
            end else begin
              r_state    <= w_tail_state;
              r_rx_ready <= rx_ready_for(w_tail_state);
              r_busy     <= (w_tail_state != ST_FIN);
              r_done     <= (w_tail_state == ST_FIN);
            end
          end
        end

        ST_CSUM: begin
          if (w_byte_fire) begin
            r_err      <= (i_rx_data != r_csum);
            r_state    <= ST_FIN;
            r_rx_ready <= rx_ready_for(ST_FIN);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_rx_ready <= 1'b0;
          r_mem_ce   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: drives framed byte streams, models a
// memory with programmable ack latency and checks writes, flags and counters.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        memCe;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memAck = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] wordsWritten;

  int total = 0;
  int bad   = 0;

  int          ackDelay   = 0;
  bit          ackAlways  = 1'b0;
  int          waitCnt    = 0;
  logic [15:0] logAddr [0:15];
  logic [15:0] logData [0:15];
  int          logN       = 0;
  int          ceCycles   = 0;
  int          stableErr  = 0;
  int          readyErr   = 0;
  int          weErr      = 0;
  logic [15:0] holdAddr;
  logic [15:0] holdData;

  inst_mem_loader dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_rx_data       (rxData),
    .i_rx_valid      (rxValid),
    .o_rx_ready      (rxReady),
    .o_mem_ce        (memCe),
    .o_mem_we        (memWe),
    .o_mem_addr      (memAddr),
    .o_mem_wdata     (memWdata),
    .i_mem_ack       (memAck),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_words_written (wordsWritten)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Memory model: acks after ackDelay waiting cycles (or always when
  // ackAlways), logs each accepted write and watches port stability.
  always @(negedge clk) begin
    if (memWe !== memCe) weErr++;
    if (memCe === 1'b1) begin
      ceCycles++;
      if (rxReady !== 1'b0) readyErr++;
      if (waitCnt == 0) begin
        holdAddr = memAddr;
        holdData = memWdata;
      end else if ((memAddr !== holdAddr) || (memWdata !== holdData)) begin
        stableErr++;
      end
      if (ackAlways || (waitCnt >= ackDelay)) begin
        memAck = 1'b1;
        if (logN < 16) begin
          logAddr[logN] = memAddr;
          logData[logN] = memWdata;
          logN++;
        end
      end else begin
        memAck = 1'b0;
      end
      waitCnt++;
    end else begin
      memAck  = ackAlways;
      waitCnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    bit got;
    got     = 1'b0;
    rxData  = b;
    rxValid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      got = (rxReady === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    rxValid = 1'b0;
    checkOutput("rx handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic resetModel();
    logN      = 0;
    ceCycles  = 0;
    stableErr = 0;
    readyErr  = 0;
  endtask

  task automatic sendFrame(input logic [15:0] base, input logic [15:0] cnt,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [7:0] csum);
    logic [15:0] w;
    applyStimulus(8'hA5);
    applyStimulus(base[7:0]);
    applyStimulus(base[15:8]);
    applyStimulus(cnt[7:0]);
    applyStimulus(cnt[15:8]);
    for (int i = 0; i < int'(cnt); i++) begin
      w = (i == 0) ? w0 : w1;
      applyStimulus(w[7:0]);
      applyStimulus(w[15:8]);
    end
    applyStimulus(csum);
  endtask

  task automatic waitDone(input string tag);
    for (int n = 0; n < 300 && (done !== 1'b1); n++) @(negedge clk);
    checkOutput(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    repeat (3) @(negedge clk);

    // reset state
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset mem_ce", {31'd0, memCe}, 32'd0);
    checkOutput("reset rx_ready", {31'd0, rxReady}, 32'd0);
    checkOutput("reset mem_addr", {16'd0, memAddr}, 32'd0);
    checkOutput("reset mem_wdata", {16'd0, memWdata}, 32'd0);
    checkOutput("reset words_written", {16'd0, wordsWritten}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle rx_ready", {31'd0, rxReady}, 32'd0);

    // basic load: csum 00^01^02^00^34^12^78^56 = 0B
    $display("[TB] basic load");
    resetModel();
    pulseStart();
    checkOutput("start busy", {31'd0, busy}, 32'd1);
    checkOutput("start rx_ready", {31'd0, rxReady}, 32'd1);
    sendFrame(16'h0100, 16'd2, 16'h1234, 16'h5678, 8'h0B);
    waitDone("basic done");
    checkOutput("basic err", {31'd0, err}, 32'd0);
    checkOutput("basic busy", {31'd0, busy}, 32'd0);
    checkOutput("basic fin rx_ready", {31'd0, rxReady}, 32'd0);
    checkOutput("basic words_written", {16'd0, wordsWritten}, 32'd2);
    checkOutput("basic write count", logN, 32'd2);
    checkOutput("basic addr0", {16'd0, logAddr[0]}, 32'h0100);
    checkOutput("basic data0", {16'd0, logData[0]}, 32'h1234);
    checkOutput("basic addr1", {16'd0, logAddr[1]}, 32'h0101);
    checkOutput("basic data1", {16'd0, logData[1]}, 32'h5678);
    checkOutput("basic ce cycles", ceCycles, 32'd2);

    // garbage before sync, memory acking permanently
    $display("[TB] garbage before sync");
    resetModel();
    ackAlways = 1'b1;
    pulseStart();
    checkOutput("restart clears done", {31'd0, done}, 32'd0);
    checkOutput("restart words_written", {16'd0, wordsWritten}, 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    sendFrame(16'h0100, 16'd2, 16'h1234, 16'h5678, 8'h0B);
    waitDone("garbage done");
    ackAlways = 1'b0;
    checkOutput("garbage err", {31'd0, err}, 32'd0);
    checkOutput("garbage write count", logN, 32'd2);
    checkOutput("garbage addr0", {16'd0, logAddr[0]}, 32'h0100);
    checkOutput("garbage data1", {16'd0, logData[1]}, 32'h5678);
    checkOutput("garbage min write cycles", ceCycles, 32'd2);

    // bad checksum, with a stray start mid-frame that must be ignored
    $display("[TB] bad checksum");
    resetModel();
    pulseStart();
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h34);
    applyStimulus(8'h12);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    applyStimulus(8'h0A);
    waitDone("badcsum done");
    checkOutput("badcsum err", {31'd0, err}, 32'd1);
    checkOutput("badcsum write count", logN, 32'd2);
    checkOutput("badcsum addr1", {16'd0, logAddr[1]}, 32'h0101);
    checkOutput("badcsum words_written", {16'd0, wordsWritten}, 32'd2);

    // slow memory: three wait cycles per write
    $display("[TB] slow memory");
    resetModel();
    ackDelay = 3;
    pulseStart();
    sendFrame(16'h0100, 16'd2, 16'h1234, 16'h5678, 8'h0B);
    waitDone("slow done");
    checkOutput("slow ce cycles", ceCycles, 32'd8);
    checkOutput("slow port stability", stableErr, 32'd0);
    checkOutput("slow rx_ready during write", readyErr, 32'd0);
    checkOutput("slow write count", logN, 32'd2);
    checkOutput("slow data0", {16'd0, logData[0]}, 32'h1234);
    checkOutput("slow err", {31'd0, err}, 32'd0);
    checkOutput("slow words_written", {16'd0, wordsWritten}, 32'd2);
    ackDelay = 0;

    // address wrap: csum FF^FF^02^00^EF^BE^FE^CA = 67
    $display("[TB] address wrap");
    resetModel();
    pulseStart();
    sendFrame(16'hFFFF, 16'd2, 16'hBEEF, 16'hCAFE, 8'h67);
    waitDone("wrap done");
    checkOutput("wrap addr0", {16'd0, logAddr[0]}, 32'hFFFF);
    checkOutput("wrap data0", {16'd0, logData[0]}, 32'hBEEF);
    checkOutput("wrap addr1", {16'd0, logAddr[1]}, 32'h0000);
    checkOutput("wrap data1", {16'd0, logData[1]}, 32'hCAFE);
    checkOutput("wrap final mem_addr", {16'd0, memAddr}, 32'h0001);
    checkOutput("wrap err", {31'd0, err}, 32'd0);

    // zero-length frame
    $display("[TB] zero count");
    resetModel();
    pulseStart();
    sendFrame(16'h0000, 16'd0, 16'h0000, 16'h0000, 8'h00);
    waitDone("zero done");
    checkOutput("zero ce cycles", ceCycles, 32'd0);
    checkOutput("zero write count", logN, 32'd0);
    checkOutput("zero err", {31'd0, err}, 32'd0);
    checkOutput("zero words_written", {16'd0, wordsWritten}, 32'd0);

    // reset while a write is pending on a very slow memory
    $display("[TB] reset mid-write");
    resetModel();
    ackDelay = 20;
    pulseStart();
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(negedge clk);
    checkOutput("midwrite ce before reset", {31'd0, memCe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midwrite ce after reset", {31'd0, memCe}, 32'd0);
    checkOutput("midwrite busy after reset", {31'd0, busy}, 32'd0);
    checkOutput("midwrite done after reset", {31'd0, done}, 32'd0);
    checkOutput("midwrite rx_ready after reset", {31'd0, rxReady}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    ackDelay = 0;
    @(negedge clk);
    resetModel();
    pulseStart();
    sendFrame(16'h0100, 16'd2, 16'h1234, 16'h5678, 8'h0B);
    waitDone("postreset done");
    checkOutput("postreset err", {31'd0, err}, 32'd0);
    checkOutput("postreset write count", logN, 32'd2);
    checkOutput("postreset addr0", {16'd0, logAddr[0]}, 32'h0100);
    checkOutput("postreset data1", {16'd0, logData[1]}, 32'h5678);
    checkOutput("mem_we tracks mem_ce", weErr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
